// File: rtl/imem_fetch_rom.sv
// imem_fetch_rom: clocked, byte-addressed instruction ROM for the fetch stage.
// Returns 32-bit big-endian words (byte[a] lands in bits 31:24); byte
// addresses wrap modulo DEPTH. A request/valid handshake with WAIT_STATES
// extra cycles models slow instruction memory.
//
// Handshake: a fetch is accepted on any rising edge where req & ready.
// rvalid is a one-cycle pulse WAIT_STATES+1 cycles after the accept edge.
// The consumer has no backpressure and must take rdata/rerr in that cycle.
// rdata/rerr hold their value after rvalid drops.
//
// Optional feature macro: IMEM_ALIGN_CHECK_EN. When defined, a fetch whose
// address is not word aligned returns rerr=1 and rdata=0. When undefined,
// unaligned fetches are legal and rerr is always 0.
module imem_fetch_rom #(
  parameter int    ADDR_W      = 9,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = "test-file.txt"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              rerr,
  output logic [1:0]        fsm_state
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  logic [7:0]        mem [0:DEPTH-1];
  state_t            state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              accept;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [31:0]       word_d;
  logic              err_d;

  // Handshake outputs are forced low while reset is high so a fetch in
  // flight when reset arrives never produces a response.
  assign ready     = ~reset & (state != WAIT);
  assign rvalid    = ~reset & (state == RESP);
  assign accept    = req & ready;
  assign fsm_state = state;

  // Next-state logic: IDLE and RESP both accept; WAIT counts down to RESP.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = addr_q;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          addr_d = addr;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt - 4'd1;
        if (cnt == 4'd1) state_d = RESP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Word assembly uses the address that addr_q will hold after this edge,
  // so a zero-wait fetch reads the address being accepted right now.
  always_comb begin
    a0     = addr_d;
    a1     = addr_d + ADDR_W'(1);
    a2     = addr_d + ADDR_W'(2);
    a3     = addr_d + ADDR_W'(3);
    word_d = {mem[a0], mem[a1], mem[a2], mem[a3]};
    err_d  = 1'b0;
`ifdef IMEM_ALIGN_CHECK_EN
    if (a0[1:0] != 2'b00) begin
      word_d = 32'h0;
      err_d  = 1'b1;
    end
`endif
  end

  // State, counter and latched address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      addr_q <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      addr_q <= addr_d;
    end
  end

  // Response data is captured only on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= 32'h0;
      rerr  <= 1'b0;
    end else if (state_d == RESP) begin
      rdata <= word_d;
      rerr  <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch_rom.sv
// Bench for imem_fetch_rom: three instances (WAIT_STATES 0, 3, 2) sharing
// one clock, a cycle-accurate scoreboard monitor, a vector table and a few
// hand-written sequences for reset and wait-state corner cases.
module tb_imem_fetch_rom;

  localparam int W = 51; // {inst[50:49], due[48:33], err[32], data[31:0]}

  logic        clk;
  logic        reset_v  [3];
  logic        req_v    [3];
  logic [8:0]  addr_v   [3];
  logic        ready_v  [3];
  logic        rvalid_v [3];
  logic [31:0] rdata_v  [3];
  logic        rerr_v   [3];
  logic [1:0]  st_v     [3];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [W-1:0] exp_q[$];
  logic [31:0]  last_d    [3];
  logic         last_e    [3];
  logic         have_last [3];

  imem_fetch_rom #(.ADDR_W(9), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
    .clk(clk), .reset(reset_v[0]), .req(req_v[0]), .addr(addr_v[0]),
    .ready(ready_v[0]), .rvalid(rvalid_v[0]), .rdata(rdata_v[0]),
    .rerr(rerr_v[0]), .fsm_state(st_v[0]));

  imem_fetch_rom #(.ADDR_W(9), .WAIT_STATES(3), .INIT_FILE("")) dut3 (
    .clk(clk), .reset(reset_v[1]), .req(req_v[1]), .addr(addr_v[1]),
    .ready(ready_v[1]), .rvalid(rvalid_v[1]), .rdata(rdata_v[1]),
    .rerr(rerr_v[1]), .fsm_state(st_v[1]));

  imem_fetch_rom #(.ADDR_W(9), .WAIT_STATES(2), .INIT_FILE("")) dut2 (
    .clk(clk), .reset(reset_v[2]), .req(req_v[2]), .addr(addr_v[2]),
    .ready(ready_v[2]), .rvalid(rvalid_v[2]), .rdata(rdata_v[2]),
    .rerr(rerr_v[2]), .fsm_state(st_v[2]));

  // Clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws_of(int inst);
    if (inst == 1) return 3;
    if (inst == 2) return 2;
    return 0;
  endfunction

  // Preload image: instance 2 carries the wrap-around pattern.
  function automatic logic [7:0] byte_at(int inst, int i);
    if (inst == 2) begin
      case (i)
        510: return 8'hAA;
        511: return 8'hBB;
        0:   return 8'hCC;
        1:   return 8'hDD;
        2:   return 8'hEE;
        3:   return 8'hFF;
        default: ;
      endcase
    end
    if (i < 8) return 8'(i + 1);
    return 8'((i * 7 + 3) & 255);
  endfunction

  function automatic logic [32:0] exp_word(int inst, int a);
    logic [31:0] w;
    logic        e;
    w = {byte_at(inst, a % 512), byte_at(inst, (a + 1) % 512),
         byte_at(inst, (a + 2) % 512), byte_at(inst, (a + 3) % 512)};
    e = 1'b0;
`ifdef IMEM_ALIGN_CHECK_EN
    if ((a % 4) != 0) begin
      w = 32'h0;
      e = 1'b1;
    end
`endif
    return {e, w};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: models ready/rvalid timing per instance, pushes an
  // expected word on every accept and pops it when rvalid is due.
  always @(negedge clk) begin
    int           k;
    logic         has;
    int           due;
    logic         exp_rdy;
    logic [W-1:0] e;
    logic [32:0]  ew;
    for (int i = 0; i < 3; i++) begin
      k = -1;
      for (int j = 0; j < exp_q.size(); j++) begin
        if (int'(exp_q[j][50:49]) == i) begin
          k = j;
          break;
        end
      end
      has = (k >= 0);
      e   = has ? exp_q[k] : '0;
      due = int'(e[48:33]);
      exp_rdy = !reset_v[i] && !(has && cyc < due);
      chk($sformatf("ready[%0d]", i), 32'(ready_v[i]), 32'(exp_rdy));
      if (!reset_v[i] && has && due == cyc) begin
        chk($sformatf("rvalid[%0d]", i), 32'(rvalid_v[i]), 32'd1);
        chk($sformatf("rdata[%0d]", i), rdata_v[i], e[31:0]);
        chk($sformatf("rerr[%0d]", i), 32'(rerr_v[i]), 32'(e[32]));
        exp_q.delete(k);
        last_d[i]    = e[31:0];
        last_e[i]    = e[32];
        have_last[i] = 1'b1;
      end else begin
        chk($sformatf("rvalid_idle[%0d]", i), 32'(rvalid_v[i]), 32'd0);
        if (have_last[i]) begin
          chk($sformatf("rdata_hold[%0d]", i), rdata_v[i], last_d[i]);
          chk($sformatf("rerr_hold[%0d]", i), 32'(rerr_v[i]), 32'(last_e[i]));
        end
      end
      if (reset_v[i]) begin
        for (int j = exp_q.size() - 1; j >= 0; j--)
          if (int'(exp_q[j][50:49]) == i) exp_q.delete(j);
        last_d[i]    = 32'h0;
        last_e[i]    = 1'b0;
        have_last[i] = 1'b1;
      end else if (req_v[i] && exp_rdy) begin
        ew = exp_word(i, int'(addr_v[i]));
        exp_q.push_back({2'(i), 16'(cyc + ws_of(i) + 1), ew});
      end
    end
  end

  typedef struct {
    int          inst;
    logic [8:0]  addr;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t tab[9];

  initial begin
    int n_rv;
    int got;
    int ii;

    // Vector table: expected words worked out by hand from the preload image.
    tab[0] = '{0, 9'd0,   32'h01020304, 1'b0};
    tab[1] = '{0, 9'd4,   32'h05060708, 1'b0};
    tab[2] = '{1, 9'd4,   32'h05060708, 1'b0};
    tab[3] = '{2, 9'd0,   32'hCCDDEEFF, 1'b0};
    tab[4] = '{0, 9'd8,   32'h3B424950, 1'b0};
    tab[5] = '{0, 9'd508, 32'hE7EEF5FC, 1'b0};
`ifdef IMEM_ALIGN_CHECK_EN
    tab[6] = '{2, 9'd510, 32'h00000000, 1'b1};
    tab[7] = '{0, 9'd2,   32'h00000000, 1'b1};
    tab[8] = '{0, 9'd511, 32'h00000000, 1'b1};
`else
    tab[6] = '{2, 9'd510, 32'hAABBCCDD, 1'b0};
    tab[7] = '{0, 9'd2,   32'h03040506, 1'b0};
    tab[8] = '{0, 9'd511, 32'hFC010203, 1'b0};
`endif

    for (int i = 0; i < 3; i++) begin
      reset_v[i]   = 1'b1;
      req_v[i]     = 1'b1;
      addr_v[i]    = 9'd0;
      have_last[i] = 1'b0;
      last_d[i]    = 32'h0;
      last_e[i]    = 1'b0;
    end
    for (int i = 0; i < 512; i++) begin
      dut0.mem[i] = byte_at(0, i);
      dut3.mem[i] = byte_at(1, i);
      dut2.mem[i] = byte_at(2, i);
    end

    // Reset held for 3 cycles with req high on every instance.
    repeat (3) cycle();
    for (int i = 0; i < 3; i++) begin
      reset_v[i] = 1'b0;
      req_v[i]   = 1'b0;
    end
    repeat (2) cycle();

    // Zero-wait back-to-back fetches on instance 0.
    req_v[0] = 1'b1; addr_v[0] = 9'd0;
    cycle();
    addr_v[0] = 9'd4;
    cycle();
    req_v[0] = 1'b0;
    repeat (3) cycle();

    // Three wait states, req held through the WAIT cycles.
    req_v[1] = 1'b1; addr_v[1] = 9'd4;
    repeat (4) cycle();
    req_v[1] = 1'b0;
    n_rv = 0;
    repeat (8) begin
      @(negedge clk);
      if (rvalid_v[1]) n_rv++;
    end
    chk("ws3_rvalid_count", 32'(n_rv), 32'd1);
    cycle();

    // Reset pulse during WAIT discards the fetch.
    req_v[2] = 1'b1; addr_v[2] = 9'd0;
    cycle();
    req_v[2] = 1'b0; reset_v[2] = 1'b1;
    cycle();
    reset_v[2] = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(ready_v[2]), 32'd1);
    n_rv = 0;
    repeat (8) begin
      @(negedge clk);
      if (rvalid_v[2]) n_rv++;
    end
    chk("discarded_rvalid_count", 32'(n_rv), 32'd0);
    cycle();

    // Table-driven single fetches.
    for (int n = 0; n < 9; n++) begin
      ii = tab[n].inst;
      req_v[ii] = 1'b1; addr_v[ii] = tab[n].addr;
      cycle();
      req_v[ii] = 1'b0;
      got = 0;
      for (int t = 0; t < 25; t++) begin
        @(negedge clk);
        if (rvalid_v[ii]) begin
          chk($sformatf("tab%0d_rdata", n), rdata_v[ii], tab[n].data);
          chk($sformatf("tab%0d_rerr", n), 32'(rerr_v[ii]), 32'(tab[n].err));
          got = 1;
          break;
        end
      end
      if (got == 0) chk($sformatf("tab%0d_timeout", n), 32'd0, 32'd1);
      cycle();
    end

    // Random traffic on the 0- and 3-wait-state instances.
    for (int n = 0; n < 80; n++) begin
      req_v[0]  = 1'($urandom_range(0, 1));
      addr_v[0] = 9'($urandom_range(0, 511));
      req_v[1]  = 1'($urandom_range(0, 1));
      addr_v[1] = 9'($urandom_range(0, 511));
      cycle();
    end
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    repeat (8) cycle();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
